// File: rtl/ram_arbiter.sv
// Two-port arbiter/sequencer for a registered-read single-port RAM.
// Optional build macro RAM_ARB_FIXED_PRIO_EN selects fixed priority (port 0) instead of round-robin.
module ram_arbiter #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic                  we0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic                  req1,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata0,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic                  ram_cs,
  output logic                  ram_we,
  output logic                  ram_oe,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    RCAPT = 2'd3
  } state_t;

  state_t state;
  logic   owner;
`ifndef RAM_ARB_FIXED_PRIO_EN
  logic   last_gnt;
`endif

  logic                  accept_c;
  logic                  sel_c;
  logic                  sel_we_c;
  logic [ADDR_WIDTH-1:0] sel_addr_c;
  logic [DATA_WIDTH-1:0] sel_wdata_c;

  // Grant selection; nothing is accepted while the RAM is mid-read or in reset.
  always_comb begin
    accept_c = 1'b0;
    sel_c    = 1'b0;
    if (!rst && state != READ) begin
      if (req0 && req1) begin
        accept_c = 1'b1;
`ifdef RAM_ARB_FIXED_PRIO_EN
        sel_c    = 1'b0;
`else
        sel_c    = ~last_gnt;
`endif
      end else if (req0) begin
        accept_c = 1'b1;
      end else if (req1) begin
        accept_c = 1'b1;
        sel_c    = 1'b1;
      end
    end
  end

  assign gnt0        = accept_c & ~sel_c;
  assign gnt1        = accept_c &  sel_c;
  assign sel_we_c    = sel_c ? we1    : we0;
  assign sel_addr_c  = sel_c ? addr1  : addr0;
  assign sel_wdata_c = sel_c ? wdata1 : wdata0;

  // Sequencer: RAM controls stay put through READ and RCAPT so the tri-stated data is stable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= 1'b0;
`ifndef RAM_ARB_FIXED_PRIO_EN
      last_gnt  <= 1'b1;
`endif
      rvalid0   <= 1'b0;
      rvalid1   <= 1'b0;
      rdata0    <= '0;
      rdata1    <= '0;
      ram_cs    <= 1'b0;
      ram_we    <= 1'b0;
      ram_oe    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;

      if (state == RCAPT) begin
        if (owner) begin
          rdata1  <= ram_rdata;
          rvalid1 <= 1'b1;
        end else begin
          rdata0  <= ram_rdata;
          rvalid0 <= 1'b1;
        end
      end

      if (state == READ) begin
        state <= RCAPT;
      end else if (accept_c) begin
`ifndef RAM_ARB_FIXED_PRIO_EN
        last_gnt <= sel_c;
`endif
        ram_cs   <= 1'b1;
        ram_addr <= sel_addr_c;
        if (sel_we_c) begin
          ram_we    <= 1'b1;
          ram_oe    <= 1'b0;
          ram_wdata <= sel_wdata_c;
          state     <= WRITE;
        end else begin
          ram_we <= 1'b0;
          ram_oe <= 1'b1;
          owner  <= sel_c;
          state  <= READ;
        end
      end else begin
        // Address and write data are left as-is when the RAM goes idle.
        ram_cs <= 1'b0;
        ram_we <= 1'b0;
        ram_oe <= 1'b0;
        state  <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed self-checking bench for ram_arbiter with a behavioural registered-read tri-state RAM.
module tb_ram_arbiter;

  logic       clk;
  logic       rst;
  logic       req0, we0, req1, we1;
  logic [7:0] addr0, wdata0, addr1, wdata1;
  logic       gnt0, gnt1, rvalid0, rvalid1;
  logic [7:0] rdata0, rdata1;
  logic       ram_cs, ram_we, ram_oe;
  logic [7:0] ram_addr, ram_wdata;
  wire  [7:0] ram_rdata;

  int checks = 0;
  int errors = 0;

  ram_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1),
    .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_oe(ram_oe),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: synchronous write, registered read, output driven only while cs && !we && oe.
  logic [7:0] mem [256];
  logic [7:0] ram_q;
  always @(posedge clk) begin
    if (ram_cs && ram_we) mem[ram_addr] <= ram_wdata;
    if (ram_cs && !ram_we) ram_q <= mem[ram_addr];
  end
  assign ram_rdata = (ram_cs && !ram_we && ram_oe) ? ram_q : 8'hzz;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0 = 1'b0; we0 = 1'b0; addr0 = 8'h00; wdata0 = 8'h00;
    req1 = 1'b0; we1 = 1'b0; addr1 = 8'h00; wdata1 = 8'h00;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    #2;
    checks++; if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin errors++; $display("FAIL rst_gnt: got %b%b expected 00", gnt0, gnt1); end
    checks++; if ({ram_cs, ram_we, ram_oe} !== 3'b000) begin errors++; $display("FAIL rst_ctrl: got %b expected 000", {ram_cs, ram_we, ram_oe}); end
    checks++; if (ram_addr !== 8'h00 || ram_wdata !== 8'h00) begin errors++; $display("FAIL rst_bus: got %h/%h expected 00/00", ram_addr, ram_wdata); end
    checks++; if ({rvalid0, rvalid1} !== 2'b00 || rdata0 !== 8'h00 || rdata1 !== 8'h00) begin errors++; $display("FAIL rst_rd: got %b %h %h expected 00 00 00", {rvalid0, rvalid1}, rdata0, rdata1); end
    req0 = 1'b1;
    #1;
    checks++; if (gnt0 !== 1'b0) begin errors++; $display("FAIL rst_gnt_req: got %b expected 0", gnt0); end
    req0 = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_write_read();
    req0 = 1'b1; we0 = 1'b1; addr0 = 8'h10; wdata0 = 8'hA5;
    #1;
    checks++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin errors++; $display("FAIL wr_gnt: got %b%b expected 10", gnt0, gnt1); end
    step();
    we0 = 1'b0;
    checks++; if ({ram_cs, ram_we, ram_oe} !== 3'b110 || ram_addr !== 8'h10 || ram_wdata !== 8'hA5) begin errors++; $display("FAIL wr_bus: got %b %h %h expected 110 10 a5", {ram_cs, ram_we, ram_oe}, ram_addr, ram_wdata); end
    checks++; if (gnt0 !== 1'b1) begin errors++; $display("FAIL rd_gnt: got %b expected 1", gnt0); end
    step();
    req0 = 1'b0;
    checks++; if ({ram_cs, ram_we, ram_oe} !== 3'b101 || ram_addr !== 8'h10) begin errors++; $display("FAIL rd_bus: got %b %h expected 101 10", {ram_cs, ram_we, ram_oe}, ram_addr); end
    req0 = 1'b1;
    #1;
    checks++; if (gnt0 !== 1'b0) begin errors++; $display("FAIL rd_nogrant_in_read: got %b expected 0", gnt0); end
    req0 = 1'b0;
    step();
    checks++; if (rvalid0 !== 1'b0) begin errors++; $display("FAIL rd_early_rvalid: got %b expected 0", rvalid0); end
    step();
    checks++; if (rvalid0 !== 1'b1 || rdata0 !== 8'hA5 || rvalid1 !== 1'b0) begin errors++; $display("FAIL rd_data: got %b %h %b expected 1 a5 0", rvalid0, rdata0, rvalid1); end
    checks++; if (ram_cs !== 1'b0) begin errors++; $display("FAIL rd_release_cs: got %b expected 0", ram_cs); end
    step();
    checks++; if (rvalid0 !== 1'b0 || rdata0 !== 8'hA5) begin errors++; $display("FAIL rd_pulse_hold: got %b %h expected 0 a5", rvalid0, rdata0); end
  endtask

  task automatic test_round_robin();
    int exp_port [4];
    logic [7:0] exp_addr [4];
    int p0;
    int p1;
    logic [7:0] rb_data [4];
`ifdef RAM_ARB_FIXED_PRIO_EN
    exp_port = '{0, 0, 1, 1};
    exp_addr = '{8'h01, 8'h03, 8'h02, 8'h04};
`else
    exp_port = '{0, 1, 0, 1};
    exp_addr = '{8'h01, 8'h02, 8'h03, 8'h04};
`endif
    rb_data = '{8'h11, 8'h22, 8'h33, 8'h44};
    pulse_reset();
    p0 = 0;
    p1 = 0;
    for (int c = 0; c < 4; c++) begin
      req0 = (p0 < 2); we0 = 1'b1;
      addr0 = (p0 == 0) ? 8'h01 : 8'h03; wdata0 = (p0 == 0) ? 8'h11 : 8'h33;
      req1 = (p1 < 2); we1 = 1'b1;
      addr1 = (p1 == 0) ? 8'h02 : 8'h04; wdata1 = (p1 == 0) ? 8'h22 : 8'h44;
      #1;
      checks++; if (gnt0 !== (exp_port[c] == 0) || gnt1 !== (exp_port[c] == 1)) begin errors++; $display("FAIL rr_gnt%0d: got %b%b expected port %0d", c, gnt0, gnt1, exp_port[c]); end
      step();
      if (exp_port[c] == 0) p0++; else p1++;
      checks++; if (ram_cs !== 1'b1 || ram_we !== 1'b1 || ram_addr !== exp_addr[c]) begin errors++; $display("FAIL rr_bus%0d: got %b%b %h expected 11 %h", c, ram_cs, ram_we, ram_addr, exp_addr[c]); end
    end
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      req0 = 1'b1; we0 = 1'b0; addr0 = 8'(i + 1);
      step();
      req0 = 1'b0;
      step();
      step();
      checks++; if (rvalid0 !== 1'b1 || rdata0 !== rb_data[i]) begin errors++; $display("FAIL rr_readback%0d: got %b %h expected 1 %h", i, rvalid0, rdata0, rb_data[i]); end
    end
  endtask

  task automatic test_read_blocks_write();
    req1 = 1'b1; we1 = 1'b1; addr1 = 8'h20; wdata1 = 8'h3C;
    step();
    req1 = 1'b1; we1 = 1'b0; addr1 = 8'h20;
    #1;
    checks++; if (gnt1 !== 1'b1 || gnt0 !== 1'b0) begin errors++; $display("FAIL rb_gnt1: got %b%b expected 01", gnt0, gnt1); end
    step();
    req1 = 1'b0;
    req0 = 1'b1; we0 = 1'b1; addr0 = 8'h30; wdata0 = 8'h77;
    #1;
    checks++; if (gnt0 !== 1'b0) begin errors++; $display("FAIL rb_wait_read: got %b expected 0", gnt0); end
    step();
    checks++; if (gnt0 !== 1'b1) begin errors++; $display("FAIL rb_gnt_rcapt: got %b expected 1", gnt0); end
    step();
    req0 = 1'b0;
    checks++; if (rvalid1 !== 1'b1 || rdata1 !== 8'h3C || rvalid0 !== 1'b0) begin errors++; $display("FAIL rb_rdata1: got %b %h %b expected 1 3c 0", rvalid1, rdata1, rvalid0); end
    checks++; if (ram_we !== 1'b1 || ram_addr !== 8'h30 || ram_wdata !== 8'h77) begin errors++; $display("FAIL rb_write_issue: got %b %h %h expected 1 30 77", ram_we, ram_addr, ram_wdata); end
    step();
    checks++; if (rvalid1 !== 1'b0 || rvalid0 !== 1'b0) begin errors++; $display("FAIL rb_pulse: got %b%b expected 00", rvalid0, rvalid1); end
    idle_inputs();
    step();
  endtask

  task automatic test_back_to_back();
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'h01;
    #1;
    checks++; if (gnt0 !== 1'b1) begin errors++; $display("FAIL b2b_gnt0: got %b expected 1", gnt0); end
    step();
    req0 = 1'b0;
    req1 = 1'b1; we1 = 1'b0; addr1 = 8'h02;
    #1;
    checks++; if (gnt1 !== 1'b0) begin errors++; $display("FAIL b2b_wait: got %b expected 0", gnt1); end
    step();
    checks++; if (gnt1 !== 1'b1 || ram_cs !== 1'b1 || ram_oe !== 1'b1) begin errors++; $display("FAIL b2b_gnt1: got %b %b%b expected 1 11", gnt1, ram_cs, ram_oe); end
    step();
    req1 = 1'b0;
    checks++; if (rvalid0 !== 1'b1 || rdata0 !== 8'h11 || rvalid1 !== 1'b0) begin errors++; $display("FAIL b2b_rv0: got %b %h %b expected 1 11 0", rvalid0, rdata0, rvalid1); end
    checks++; if (ram_cs !== 1'b1 || ram_oe !== 1'b1 || ram_addr !== 8'h02) begin errors++; $display("FAIL b2b_ctrl_e2: got %b%b %h expected 11 02", ram_cs, ram_oe, ram_addr); end
    step();
    checks++; if (ram_cs !== 1'b1 || ram_oe !== 1'b1 || rvalid0 !== 1'b0 || rvalid1 !== 1'b0) begin errors++; $display("FAIL b2b_ctrl_e3: got %b%b %b%b expected 11 00", ram_cs, ram_oe, rvalid0, rvalid1); end
    step();
    checks++; if (rvalid1 !== 1'b1 || rdata1 !== 8'h22 || rvalid0 !== 1'b0) begin errors++; $display("FAIL b2b_rv1: got %b %h %b expected 1 22 0", rvalid1, rdata1, rvalid0); end
    step();
  endtask

  task automatic test_reset_mid_read();
    int rv_seen;
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'h03;
    step();
    req0 = 1'b0;
    checks++; if (ram_oe !== 1'b1) begin errors++; $display("FAIL mr_read_started: got %b expected 1", ram_oe); end
    rst = 1'b1;
    #1;
    checks++; if ({ram_cs, ram_we, ram_oe} !== 3'b000 || rdata0 !== 8'h00) begin errors++; $display("FAIL mr_async: got %b %h expected 000 00", {ram_cs, ram_we, ram_oe}, rdata0); end
    #2;
    rst = 1'b0;
    rv_seen = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (rvalid0 || rvalid1) rv_seen++;
    end
    checks++; if (rv_seen !== 0) begin errors++; $display("FAIL mr_no_rvalid: got %0d pulses expected 0", rv_seen); end
    req0 = 1'b1; we0 = 1'b1; addr0 = 8'h40; wdata0 = 8'h5A;
    req1 = 1'b1; we1 = 1'b1; addr1 = 8'h50; wdata1 = 8'h66;
    #1;
    checks++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin errors++; $display("FAIL mr_tie: got %b%b expected 10", gnt0, gnt1); end
    step();
    idle_inputs();
  endtask

  task automatic test_idle_hold();
    step();
    step();
    step();
    checks++; if ({ram_cs, ram_we, ram_oe} !== 3'b000) begin errors++; $display("FAIL idle_ctrl: got %b expected 000", {ram_cs, ram_we, ram_oe}); end
    checks++; if (ram_addr !== 8'h40 || ram_wdata !== 8'h5A) begin errors++; $display("FAIL idle_hold: got %h %h expected 40 5a", ram_addr, ram_wdata); end
    checks++; if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin errors++; $display("FAIL idle_gnt: got %b%b expected 00", gnt0, gnt1); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_round_robin();
    test_read_blocks_write();
    test_back_to_back();
    test_reset_mid_read();
    test_idle_hold();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port round-robin arbiter and sequencer for the team's synchronous single-port RAM (registered read, tri-stated output gated by cs/we/oe). It accepts read and write requests from two requesters over valid/ready handshakes and drives the RAM's cs/we/oe/address/data_in pins. It holds the RAM controls stable across the two-cycle read so the tri-stated read data is captured cleanly, and it returns read data to the winning requester with a one-cycle rvalid pulse.

## Interface
- DATA_WIDTH, 8, RAM word width
- ADDR_WIDTH, 8, RAM address width
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- req0 / req1  in  1  request valid, per port
- we0 / we1  in  1  1 = write, 0 = read, per port
- addr0 / addr1  in  ADDR_WIDTH  request address
- wdata0 / wdata1  in  DATA_WIDTH  write data
- gnt0 / gnt1  out  1  combinational ready; the request is accepted at any edge where reqN && gntN
- rvalid0 / rvalid1  out  1  registered one-cycle pulse; rdataN is valid
- rdata0 / rdata1  out  DATA_WIDTH  registered read data; holds until the next read for that port
- ram_cs, ram_we, ram_oe  out  1  registered RAM controls
- ram_addr  out  ADDR_WIDTH  registered RAM address
- ram_wdata  out  DATA_WIDTH  registered RAM write data
- ram_rdata  in  DATA_WIDTH  RAM data_out; high-Z except while cs && !we && oe

## Operation
- FSM states: IDLE, WRITE, READ, RCAPT.
- The arbiter may accept a request in IDLE, WRITE or RCAPT. It never accepts in READ, where gnt0 = gnt1 = 0.
- Selection when the arbiter can accept:
  - Exactly one reqN is high: that port is granted.
  - Both are high: the port not equal to last_gnt is granted.
  - At most one gnt is high in any cycle.
  - last_gnt updates on every acceptance. After reset, last_gnt = 1, so port 0 wins the first tie.
- On accepting a write:
  - ram_cs = 1, ram_we = 1, ram_oe = 0.
  - ram_addr and ram_wdata take the request's values.
  - Next state is WRITE.
- On accepting a read:
  - ram_cs = 1, ram_we = 0, ram_oe = 1.
  - ram_addr takes the request's address.
  - A 1-bit owner register records the granted port.
  - Next state is READ.
- In READ, all ram_* outputs are held and the next state is RCAPT. The RAM registers mem[addr] at this edge.
- In RCAPT:
  - ram_* outputs are held, so ram_rdata is driven by the RAM.
  - At the exiting edge, rdata[owner] <= ram_rdata and rvalid[owner] <= 1.
- Leaving WRITE or RCAPT with no acceptance: ram_cs = ram_we = ram_oe = 0, and the next state is IDLE. ram_addr and ram_wdata hold their values.
- ram_rdata is never sampled outside the RCAPT exit edge.
- Requests are processed strictly in grant order. A read issued after a write to the same address returns the new data.

## Timing
- Reset values: all outputs 0 (gnt0/1 = 0 because reset forces state IDLE with no requests evaluated as granted until rst drops). Internal state: IDLE, last_gnt = 1, owner = 0.
- Write: accepted at edge E0; the RAM writes at E1; a new request can be accepted at E1. Sustained throughput is 1 write per cycle.
- Read: accepted at E0; the RAM registers data at E1; rdataN/rvalidN are registered at E2 and visible in the cycle after E2. A new request can be accepted at E2.
- Read cost is 2 cycles. Read-to-grant latency is 2 cycles.
- rvalid is high for exactly one cycle per read, for the owner port only.
- A requester holds reqN, weN, addrN and wdataN stable until it sees gntN high at an edge. gnt depends combinationally on req; there is no combinational path from req to ram_* outputs.
- Reset asserted mid-read: the in-flight read is dropped and no rvalid is produced. All outputs return to reset values immediately (asynchronous reset).

## Configuration
- RAM_ARB_FIXED_PRIO_EN:
  - Defined: port 0 always wins when both ports request. last_gnt is not implemented, so port 1 can starve.
  - Undefined (default): round-robin as described above.
- All other behaviour is identical in both builds.

## Test plan
- Reset, then port 0 writes 0xA5 @0x10, then port 0 reads @0x10 -> gnt0 on the first cycle for each request; rvalid0 2 cycles after the read grant with rdata0 = 0xA5.
- Both ports hold write requests for 4 consecutive cycles (addresses 0x01..0x04) -> grants alternate 0,1,0,1 starting with port 0 with no idle cycle; readback returns each value. With RAM_ARB_FIXED_PRIO_EN, all port 0 requests are granted first.
- Port 1 reads @0x20 (preloaded 0x3C) while port 0 requests a write -> port 0 write waits through READ (gnt0 = 0), then is granted at the RCAPT exit edge; rvalid1 = 1, rdata1 = 0x3C, rvalid0 stays 0.
- Back-to-back reads: port 0 reads @0x01, port 1 reads @0x02 -> rvalid0 at E2 and rvalid1 at E4; ram_cs/oe stay high continuously.
- Reset pulse during READ -> ram_cs/we/oe = 0 immediately; no rvalid afterwards; the next tie is won by port 0.
- Idle for 3 cycles after a write -> ram_cs = 0; ram_addr and ram_wdata hold their last values.
